// File: rtl/zuart_tx_arbiter_pkg.sv
// zuart_tx_arbiter_pkg: shared types and widths for the ZUART transmit arbiter
package zuart_tx_arbiter_pkg;
  localparam int BYTE_W = 8;
  localparam int GAP_W  = 4;
  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_GAP  = 2'd2
  } arb_state_e;
endpackage

// File: rtl/zuart_tx_arbiter_if.sv
// zuart_tx_arbiter_if: requester byte streams on one side, ZUART_Tx drive on the other
interface zuart_tx_arbiter_if #(parameter int NUM_REQ = 3);
  import zuart_tx_arbiter_pkg::*;
  logic [NUM_REQ-1:0]        req_en;
  logic [BYTE_W*NUM_REQ-1:0] req_data;
  logic [NUM_REQ-1:0]        req_lock;
  logic [NUM_REQ-1:0]        req_done;
  logic [NUM_REQ-1:0]        grant;
  logic                      tx_en;
  logic [BYTE_W-1:0]         tx_data;
  logic                      tx_done;
  logic                      busy;
  logic                      timeout;
  logic [BYTE_W-1:0]         err_cnt;
  modport master (
    input  req_en, req_data, req_lock, tx_done,
    output req_done, grant, tx_en, tx_data, busy, timeout, err_cnt
  );
  modport slave (
    output req_en, req_data, req_lock, tx_done,
    input  req_done, grant, tx_en, tx_data, busy, timeout, err_cnt
  );
endinterface

// File: rtl/zuart_tx_arbiter_zrr_pick.sv
// zrr_pick: combinational round-robin picker, first request above last_i with wrap
module zrr_pick #(
  parameter  int N  = 3,
  localparam int IW = $clog2(N)
) (
  input  logic [N-1:0]  req_i,
  input  logic [IW-1:0] last_i,
  output logic [N-1:0]  onehot_o,
  output logic [IW-1:0] idx_o,
  output logic          valid_o
);
  logic [IW-1:0] j;
  always_comb begin
    idx_o   = last_i;
    valid_o = 1'b0;
    j       = last_i;
    // walk from farthest to nearest so the nearest request is written last
    for (int k = N; k >= 1; k--) begin
      j = IW'((int'(last_i) + k) % N);
      if (req_i[j]) begin
        idx_o   = j;
        valid_o = 1'b1;
      end
    end
    onehot_o = valid_o ? N'(1) << idx_o : '0;
  end
endmodule

// File: rtl/zuart_tx_arbiter.sv
// zuart_tx_arbiter: round-robin byte arbiter in front of the shared debug ZUART_Tx,
// with one-shot per-requester lock and a transmit watchdog.
module zuart_tx_arbiter
  import zuart_tx_arbiter_pkg::*;
#(
  parameter int NUM_REQ     = 3,
  parameter int TIMEOUT_CYC = 2000,
  parameter int GAP_CYC     = 2
) (
  input  logic                clk_i,
  input  logic                rst_i,
  zuart_tx_arbiter_if.master  bus
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = $clog2(TIMEOUT_CYC);
  arb_state_e         state_q;
  logic [IW-1:0]      last_q, pick_idx, win_d;
  logic [NUM_REQ-1:0] pick_oh, grant_d, grant_q, done_q;
  logic               pick_vld, lock_q, lock_hit, tmo_hit, tx_en_q, timeout_q, busy_q;
  logic [CW-1:0]      cnt_q;
  logic [GAP_W-1:0]   gap_q;
  logic [BYTE_W-1:0]  tx_data_q, err_q, err_d;
  zrr_pick #(.N(NUM_REQ)) u_pick (
    .req_i    (bus.req_en),
    .last_i   (last_q),
    .onehot_o (pick_oh),
    .idx_o    (pick_idx),
    .valid_o  (pick_vld)
  );
  always_comb begin
    lock_hit = lock_q & bus.req_en[last_q];
    win_d    = lock_hit ? last_q : pick_idx;
    grant_d  = lock_hit ? NUM_REQ'(1) << last_q : pick_oh;
    // a done arriving on the limit cycle wins over the watchdog
    tmo_hit  = ~bus.tx_done & (cnt_q == CW'(TIMEOUT_CYC - 1));
    err_d    = (err_q == '1) ? err_q : err_q + 1'b1;
  end
  always_ff @(posedge clk_i or posedge rst_i)
    if (rst_i) begin
      state_q   <= ARB_IDLE;
      last_q    <= IW'(NUM_REQ - 1);
      grant_q   <= '0;
      done_q    <= '0;
      tx_en_q   <= 1'b0;
      tx_data_q <= '0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      err_q     <= '0;
      lock_q    <= 1'b0;
      cnt_q     <= '0;
      gap_q     <= '0;
    end else begin
      done_q    <= '0;
      timeout_q <= 1'b0;
      case (state_q)
        ARB_IDLE: begin
          lock_q <= 1'b0;
          if (pick_vld) begin
            tx_data_q <= bus.req_data[{win_d, 3'b000} +: BYTE_W];
            grant_q   <= grant_d;
            last_q    <= win_d;
            tx_en_q   <= 1'b1;
            busy_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= ARB_SEND;
          end
        end
        ARB_SEND:
          if (bus.tx_done | tmo_hit) begin
            tx_en_q   <= 1'b0;
            done_q    <= grant_q;
            timeout_q <= tmo_hit;
            err_q     <= tmo_hit ? err_d : err_q;
            lock_q    <= bus.tx_done & |(bus.req_lock & grant_q);
            gap_q     <= '0;
            state_q   <= ARB_GAP;
          end else
            cnt_q <= cnt_q + 1'b1;
        ARB_GAP:
          if (gap_q == GAP_W'(GAP_CYC - 1)) begin
            grant_q <= '0;
            busy_q  <= 1'b0;
            state_q <= ARB_IDLE;
          end else
            gap_q <= gap_q + 1'b1;
        default: state_q <= ARB_IDLE;
      endcase
    end
  assign bus.grant    = grant_q;
  assign bus.req_done = done_q;
  assign bus.tx_en    = tx_en_q;
  assign bus.tx_data  = tx_data_q;
  assign bus.timeout  = timeout_q;
  assign bus.busy     = busy_q;
  assign bus.err_cnt  = err_q;
endmodule

// File: tb/tb_zuart_tx_arbiter.sv
// tb_zuart_tx_arbiter: scoreboard bench for the ZUART transmit arbiter
module tb_zuart_tx_arbiter;
  localparam int NR  = 3;
  localparam int TMO = 40;
  localparam int GAP = 2;
  typedef struct packed {
    logic [2:0] grant;
    logic [7:0] data;
    logic       tmo;
  } exp_t;
  logic clk = 1'b0;
  logic rst = 1'b0;
  logic uart_done = 1'b0;
  logic spur_done = 1'b0;
  int   uart_cyc = 20;
  int   n_tests = 0;
  int   n_fail = 0;
  int   hi_run = 0;
  int   last_hi = 0;
  int   low_run = 0;
  bit   en_prev = 1'b0;
  bit   chk_gap = 1'b0;
  bit   had_fall = 1'b0;
  logic [7:0] cap_data = '0;
  exp_t sb_q[$];
  zuart_tx_arbiter_if #(.NUM_REQ(NR)) bus ();
  assign bus.tx_done = uart_done | spur_done;
  zuart_tx_arbiter #(.NUM_REQ(NR), .TIMEOUT_CYC(TMO), .GAP_CYC(GAP)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic push(input logic [2:0] g, input logic [7:0] d, input logic t);
    sb_q.push_back('{grant: g, data: d, tmo: t});
  endtask
  task automatic apply_reset();
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask
  task automatic wait_done(input int limit);
    bit got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      got = |bus.req_done;
    end
    if (!got) check("wait_done", 0, 1);
  endtask
  task automatic wait_en(input int limit);
    bit got = 1'b0;
    for (int i = 0; i < limit && !got; i++) begin
      @(negedge clk);
      got = bus.tx_en;
    end
    if (!got) check("wait_en", 0, 1);
  endtask
  // UART model: done pulse uart_cyc cycles after oTxEn rises, never when uart_cyc is 0
  initial forever begin
    @(posedge bus.tx_en);
    if (uart_cyc > 0) begin
      repeat (uart_cyc - 1) @(posedge clk);
      #1 uart_done = 1'b1;
      @(posedge clk);
      #1 uart_done = 1'b0;
    end
  end
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (bus.tx_en && !en_prev) begin
        cap_data = bus.tx_data;
        if (chk_gap && had_fall) check("gap_len", low_run, GAP + 1);
        hi_run = 0;
      end
      if (!bus.tx_en && en_prev) begin
        last_hi  = hi_run;
        low_run  = 0;
        had_fall = chk_gap;
      end
      if (bus.tx_en) hi_run++;
      else low_run++;
      if (|bus.req_done) begin
        if (sb_q.size() == 0) check("sb_unexpected", bus.req_done, 0);
        else begin
          e = sb_q.pop_front();
          check("sb_grant", bus.req_done, e.grant);
          check("sb_data", cap_data, e.data);
          check("sb_tmo", bus.timeout, e.tmo);
        end
      end else if (bus.timeout) check("tmo_alone", bus.timeout, 0);
      en_prev = bus.tx_en;
    end
  end
  initial begin
    #5ms;
    $display("FAIL watchdog: simulation did not finish, %0d tests run", n_tests);
    $fatal(1);
  end
  initial begin
    bus.req_en   = '0;
    bus.req_data = '0;
    bus.req_lock = '0;
    apply_reset();
    check("rst_tx_en", bus.tx_en, 0);
    check("rst_grant", bus.grant, 0);
    check("rst_busy", bus.busy, 0);
    check("rst_err", bus.err_cnt, 0);
    check("rst_done", bus.req_done, 0);
    check("rst_tmo", bus.timeout, 0);
    uart_cyc = 30;
    bus.req_data[7:0] = 8'h55;
    bus.req_en = 3'b001;
    push(3'b001, 8'h55, 1'b0);
    check("single_pre_en", bus.tx_en, 0);
    @(negedge clk);
    check("single_en", bus.tx_en, 1);
    check("single_data", bus.tx_data, 8'h55);
    check("single_grant", bus.grant, 3'b001);
    check("single_busy", bus.busy, 1);
    wait_done(200);
    bus.req_en = '0;
    check("single_gap_grant0", bus.grant, 3'b001);
    check("single_gap_en", bus.tx_en, 0);
    @(negedge clk);
    check("single_done_pulse", bus.req_done, 0);
    check("single_gap_grant1", bus.grant, 3'b001);
    check("single_hi", last_hi, 30);
    @(negedge clk);
    check("single_idle_grant", bus.grant, 0);
    check("single_idle_busy", bus.busy, 0);
    apply_reset();
    bus.req_data = {8'hA2, 8'hA1, 8'hA0};
    for (int i = 0; i < 6; i++) push(3'(1 << (i % 3)), 8'(8'hA0 + i % 3), 1'b0);
    chk_gap = 1'b1;
    bus.req_en = 3'b111;
    for (int i = 0; i < 6; i++) wait_done(200);
    bus.req_en = '0;
    chk_gap = 1'b0;
    apply_reset();
    bus.req_data = {8'h32, 8'h4F, 8'h30};
    bus.req_lock = 3'b010;
    bus.req_en = 3'b010;
    push(3'b010, 8'h4F, 1'b0);
    push(3'b010, 8'h4B, 1'b0);
    push(3'b010, 8'h0A, 1'b0);
    push(3'b100, 8'h32, 1'b0);
    push(3'b001, 8'h30, 1'b0);
    wait_en(50);
    bus.req_en = 3'b111;
    wait_done(200);
    bus.req_data[15:8] = 8'h4B;
    wait_done(200);
    bus.req_data[15:8] = 8'h0A;
    bus.req_lock = '0;
    wait_done(200);
    bus.req_en = 3'b101;
    wait_done(200);
    wait_done(200);
    bus.req_en = '0;
    apply_reset();
    uart_cyc = 0;
    bus.req_data[7:0] = 8'h77;
    bus.req_en = 3'b001;
    push(3'b001, 8'h77, 1'b1);
    wait_done(TMO + 20);
    @(negedge clk);
    check("tmo_pulse", bus.timeout, 0);
    check("tmo_hi", last_hi, TMO);
    check("tmo_err1", bus.err_cnt, 1);
    for (int i = 2; i <= 257; i++) begin
      push(3'b001, 8'h77, 1'b1);
      wait_done(TMO + 20);
      if (i == 255) check("tmo_err255", bus.err_cnt, 255);
    end
    bus.req_en = '0;
    check("tmo_err_sat", bus.err_cnt, 255);
    repeat (4) @(negedge clk);
    apply_reset();
    uart_cyc = TMO;
    bus.req_data[7:0] = 8'h5A;
    bus.req_en = 3'b001;
    push(3'b001, 8'h5A, 1'b0);
    wait_done(TMO + 20);
    bus.req_en = '0;
    @(negedge clk);
    check("bnd_hi", last_hi, TMO);
    check("bnd_err", bus.err_cnt, 0);
    repeat (4) @(negedge clk);
    spur_done = 1'b1;
    @(negedge clk);
    spur_done = 1'b0;
    check("spur_en", bus.tx_en, 0);
    check("spur_busy", bus.busy, 0);
    check("spur_grant", bus.grant, 0);
    @(negedge clk);
    check("spur_done_o", bus.req_done, 0);
    check("spur_err", bus.err_cnt, 0);
    uart_cyc = 0;
    bus.req_data[15:8] = 8'hE1;
    bus.req_en = 3'b010;
    wait_en(50);
    repeat (20) @(negedge clk);
    @(posedge clk);
    #2 rst = 1'b1;
    #1;
    check("mid_rst_en", bus.tx_en, 0);
    check("mid_rst_grant", bus.grant, 0);
    check("mid_rst_busy", bus.busy, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("mid_rst_done", bus.req_done, 0);
    end
    rst = 1'b0;
    uart_cyc = 20;
    bus.req_data = {8'h00, 8'hE1, 8'hE0};
    bus.req_en = 3'b011;
    push(3'b001, 8'hE0, 1'b0);
    push(3'b010, 8'hE1, 1'b0);
    wait_done(200);
    wait_done(200);
    bus.req_en = '0;
    repeat (4) @(negedge clk);
    check("sb_left", sb_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/zuart_tx_arbiter.md
Name: zuart_tx_arbiter

Overview:
Shares the single debug ZUART_Tx (1 Mbaud at 100 MHz) between several byte-stream requesters: OV5640 config, HyperRAM, DVP and spares. It replaces the static UART multiplexer with round-robin byte arbitration. An optional per-requester lock keeps multi-byte messages contiguous. A timeout watchdog keeps a hung transmitter from stalling the whole system. It sits between the requester modules and ZUART_Tx in the top level, in the 100 MHz system clock domain.

Parameters:
NUM_REQ, 3, number of requesters (2..8).
TIMEOUT_CYC, 2000, clock cycles allowed between oTxEn rise and iTxDone (one byte is 1000 cycles).
GAP_CYC, 2, idle cycles with oTxEn low after each byte (1..15).

Ports:
iClk  in  1  system clock, 100 MHz.
iRst  in  1  asynchronous reset, active high.
iReqEn  in  NUM_REQ  per-requester request level; data is valid while high.
iReqData  in  8*NUM_REQ  byte for requester i, at bits [8i+7:8i].
iReqLock  in  NUM_REQ  requester i asks to keep its grant for its next byte.
oReqDone  out  NUM_REQ  one-cycle pulse to the granted requester when its byte is finished (sent or timed out).
oGrant  out  NUM_REQ  one-hot grant of the current owner; all zero when IDLE.
oTxEn  out  1  drive to ZUART_Tx iEn.
oTxData  out  8  drive to ZUART_Tx iData; held stable while oTxEn is high.
iTxDone  in  1  ZUART_Tx oDone pulse.
oBusy  out  1  high in every state except IDLE.
oTimeout  out  1  one-cycle pulse when a byte is aborted by the watchdog.
oErrCnt  out  8  count of timeouts; saturates at 255 and is cleared only by reset.

Behaviour:
- Reset values: all outputs 0. last_grant = NUM_REQ-1, so requester 0 wins first. State = IDLE. Counters = 0.
- States: IDLE, SEND, GAP.
- IDLE:
  - If any iReqEn is high, pick the winner w.
  - If the lock is held and the locked requester is requesting, w is the locked requester.
  - Otherwise w is the first requesting index after last_grant, searching upward with wrap.
  - On that cycle: register oTxData = iReqData[w], set oGrant = onehot(w), set oTxEn = 1, set last_grant = w, clear the timeout counter, go to SEND.
  - Latency: iReqEn rising at edge t gives oTxEn high at edge t+1.
- SEND:
  - oTxEn and oTxData are held; the timeout counter increments each cycle.
  - If iTxDone = 1: at the next edge oTxEn = 0, oReqDone[w] pulses for 1 cycle, lock_valid = iReqLock[w] sampled on that cycle, go to GAP.
  - Else if the counter reaches TIMEOUT_CYC-1: same exit, plus oTimeout pulses, oErrCnt increments (saturating), and lock_valid = 0.
  - If done and the timeout limit occur in the same cycle, done wins: no timeout is counted.
- GAP:
  - oGrant stays at w and oTxEn stays 0 for GAP_CYC cycles, then go to IDLE and clear oGrant.
  - The requester updates iReqData and iReqEn during GAP; its data is sampled only at grant.
- Lock: honoured only for the next arbitration.
  - If the locked requester is not requesting in the IDLE cycle, lock_valid clears and normal round-robin applies.
  - A lock never extends past one IDLE evaluation.
- A requester that drops iReqEn while in SEND does not cancel the byte. The byte completes and oReqDone still pulses.
- iReqEn changes on non-granted requesters have no effect until IDLE.
- An iTxDone pulse outside SEND is ignored.
- Reset asserted mid-byte forces everything to its reset values immediately; no oReqDone pulse is produced.
- Steady-state throughput per byte is the UART time plus 1 (IDLE) plus GAP_CYC cycles.

Decomposition:
- Add ZUART_ARB_IDLE, ZUART_ARB_SEND and ZUART_ARB_GAP state encodings to ZPortableDefine.v, next to the STEP_xx defines.
- Sub-module zrr_pick (combinational round-robin picker: request vector and last index in, one-hot and index out). It is reusable for the planned HyperRAM port arbiter.

Test Plan:
- Single requester: req0 sends 0x55, UART model done after 1000 cycles -> oTxEn at t+1, oTxData = 0x55, oReqDone[0] one cycle after done, oGrant = 001 through GAP, then 000.
- Contention: req0, req1 and req2 high continuously, no locks -> grant order 0,1,2,0,1,2 over 6 bytes, each byte separated by exactly GAP_CYC+1 cycles with oTxEn low.
- Lock: req1 sends "OK\n" with iReqLock = 1 on the first two bytes while req0 and req2 request -> bytes 0x4F, 0x4B, 0x0A contiguous on req1, then grant passes to 2 then 0.
- Timeout: UART model never returns done -> oTxEn drops after 2000 cycles, oTimeout and oReqDone[w] pulse together, oErrCnt = 1. After 256 timeouts oErrCnt stays at 255.
- Boundary: iTxDone in the same cycle the counter reaches 1999 -> no oTimeout, oErrCnt unchanged. A spurious iTxDone in IDLE -> no state change.
- Reset mid-SEND: assert iRst for 3 cycles at cycle 500 of a byte -> oTxEn, oGrant and oBusy go to 0 asynchronously, no oReqDone; after release, requester 0 wins first.
